// File: rtl/flag_branch_unit_pkg.sv
// Shared definitions for the WISC flag register / branch resolution path:
// condition codes, flag write masks and the branch FSM state encoding.
package flag_branch_unit_pkg;

    localparam logic [2:0] COND_NEQ    = 3'b000;
    localparam logic [2:0] COND_EQ     = 3'b001;
    localparam logic [2:0] COND_GT     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GTE    = 3'b100;
    localparam logic [2:0] COND_LTE    = 3'b101;
    localparam logic [2:0] COND_OVFL   = 3'b110;
    localparam logic [2:0] COND_UNCOND = 3'b111;

    // flag_we bit order is {N,Z,V}
    localparam logic [2:0] FWE_ALL  = 3'b111;
    localparam logic [2:0] FWE_Z    = 3'b010;
    localparam logic [2:0] FWE_NONE = 3'b000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESOLVE = 2'd2
    } state_e;

endpackage

// File: rtl/flag_branch_unit_cond_eval.sv
// Combinational condition-code evaluator: maps (cond, N, Z, V) to taken.
// Shared with the decode-stage predictor checker.
module branch_cond_eval
    import flag_branch_unit_pkg::*;
(
    input  logic [2:0] i_cond,
    input  logic       i_n,
    input  logic       i_z,
    input  logic       i_v,
    output logic       o_taken
);

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            COND_NEQ:    o_taken = ~i_z;
            COND_EQ:     o_taken = i_z;
            COND_GT:     o_taken = ~i_z & ~i_n;
            COND_LT:     o_taken = i_n;
            COND_GTE:    o_taken = i_z | (~i_z & ~i_n);
            COND_LTE:    o_taken = i_n | i_z;
            COND_OVFL:   o_taken = i_v;
            COND_UNCOND: o_taken = 1'b1;
            default:     o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural N/Z/V flag register plus conditional branch resolver.
// Branches wait out in-flight flag writers, then resolve against forwarded flags.
module flag_branch_unit
    import flag_branch_unit_pkg::*;
#(
    parameter int DW    = 16,
    parameter int IMM_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_v,
    input  logic [2:0]       flag_we,
    input  logic             flag_pend,
    input  logic             br_req,
    output logic             br_rdy,
    input  logic             br_reg,
    input  logic [2:0]       br_cond,
    input  logic [DW-1:0]    br_pc2,
    input  logic [IMM_W-1:0] br_imm,
    input  logic [DW-1:0]    br_rs,
    output logic [2:0]       flags,
    output logic             rd_valid,
    output logic             rd_taken,
    output logic [DW-1:0]    rd_target,
    output logic             flush
);

    state_e          r_state, w_next;
    logic [2:0]      r_flags, w_eff;
    logic [2:0]      r_cond;
    logic [DW-1:0]   r_tgt, r_pc2;
    logic [DW-1:0]   w_imm_sx, w_b_tgt;
    logic            w_taken, w_accept, w_resolve;
    logic            r_rd_valid, r_rd_taken, r_flush;
    logic [DW-1:0]   r_rd_target;

    // Same-cycle flag writes are forwarded into branch evaluation
    assign w_eff     = (flag_we & {alu_n, alu_z, alu_v}) | (~flag_we & r_flags);
    assign w_imm_sx  = {{(DW-IMM_W){br_imm[IMM_W-1]}}, br_imm};
    assign w_b_tgt   = br_pc2 + (w_imm_sx << 1);
    assign w_accept  = (r_state == IDLE) & br_req;
    assign w_resolve = (r_state == RESOLVE);

    branch_cond_eval u_cond (
        .i_cond  (r_cond),
        .i_n     (w_eff[2]),
        .i_z     (w_eff[1]),
        .i_v     (w_eff[0]),
        .o_taken (w_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (br_req)     w_next = flag_pend ? WAIT : RESOLVE;
            WAIT:    if (!flag_pend) w_next = RESOLVE;
            RESOLVE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        br_rdy = 1'b0;
        if (r_state == IDLE) br_rdy = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags     <= 3'b000;
            r_cond      <= 3'b000;
            r_tgt       <= '0;
            r_pc2       <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_taken  <= 1'b0;
            r_rd_target <= '0;
            r_flush     <= 1'b0;
        end else begin
            r_flags    <= w_eff;
            r_rd_valid <= w_resolve;
            r_flush    <= w_resolve & w_taken;
            // Target is flag-independent, so it is computed once at accept
            if (w_accept) begin
                r_cond <= br_cond;
                r_pc2  <= br_pc2;
                r_tgt  <= br_reg ? br_rs : w_b_tgt;
            end
            if (w_resolve) begin
                r_rd_taken  <= w_taken;
                r_rd_target <= w_taken ? r_tgt : r_pc2;
            end
        end
    end

    assign flags     = r_flags;
    assign rd_valid  = r_rd_valid;
    assign rd_taken  = r_rd_taken;
    assign rd_target = r_rd_target;
    assign flush     = r_flush;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: event-level reference model compared
// every cycle, plus hand-computed literal expectations.
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_n, alu_z, alu_v;
    logic [2:0]  flag_we;
    logic        flag_pend;
    logic        br_req;
    logic        br_rdy;
    logic        br_reg;
    logic [2:0]  br_cond;
    logic [15:0] br_pc2;
    logic [8:0]  br_imm;
    logic [15:0] br_rs;
    logic [2:0]  flags;
    logic        rd_valid, rd_taken, flush;
    logic [15:0] rd_target;

    int n_tests = 0;
    int n_fail  = 0;

    flag_branch_unit #(.DW(16), .IMM_W(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_n     (alu_n),
        .alu_z     (alu_z),
        .alu_v     (alu_v),
        .flag_we   (flag_we),
        .flag_pend (flag_pend),
        .br_req    (br_req),
        .br_rdy    (br_rdy),
        .br_reg    (br_reg),
        .br_cond   (br_cond),
        .br_pc2    (br_pc2),
        .br_imm    (br_imm),
        .br_rs     (br_rs),
        .flags     (flags),
        .rd_valid  (rd_valid),
        .rd_taken  (rd_taken),
        .rd_target (rd_target),
        .flush     (flush)
    );

    initial forever #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic cond_taken(input logic [2:0] c, input logic [2:0] f);
        logic n, z, v;
        {n, z, v} = f;
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || (!z && !n);
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] b_target(input logic [15:0] pc2, input logic [8:0] imm);
        int t;
        t = int'(pc2) + 2 * int'($signed(imm));
        return t[15:0];
    endfunction

    logic [2:0]  m_flags, m_cond;
    logic        m_busy, m_eval, m_valid, m_taken;
    logic [15:0] m_target, m_tgt, m_pc2;
    wire  [2:0]  m_eff = (flag_we & {alu_n, alu_z, alu_v}) | (~flag_we & m_flags);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flags <= 3'b000; m_cond <= 3'b000;
            m_busy <= 1'b0; m_eval <= 1'b0; m_valid <= 1'b0; m_taken <= 1'b0;
            m_target <= 16'h0; m_tgt <= 16'h0; m_pc2 <= 16'h0;
        end else begin
            m_flags <= m_eff;
            m_valid <= m_eval;
            if (m_eval) begin
                m_taken  <= cond_taken(m_cond, m_eff);
                m_target <= cond_taken(m_cond, m_eff) ? m_tgt : m_pc2;
                m_busy   <= 1'b0;
                m_eval   <= 1'b0;
            end else if (m_busy) begin
                m_eval <= !flag_pend;
            end else if (br_req) begin
                m_busy <= 1'b1;
                m_eval <= !flag_pend;
                m_cond <= br_cond;
                m_pc2  <= br_pc2;
                m_tgt  <= br_reg ? br_rs : b_target(br_pc2, br_imm);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("cyc_flags",     32'(flags),     32'(m_flags));
        chk("cyc_br_rdy",    32'(br_rdy),    32'(!m_busy));
        chk("cyc_rd_valid",  32'(rd_valid),  32'(m_valid));
        chk("cyc_rd_taken",  32'(rd_taken),  32'(m_taken));
        chk("cyc_rd_target", 32'(rd_target), 32'(m_target));
        chk("cyc_flush",     32'(flush),     32'(m_valid & m_taken));
    end

    // ---------------- stimulus ----------------
    task automatic nc();
        @(negedge clk);
    endtask

    task automatic setf(input logic [2:0] f);
        flag_we = 3'b111; {alu_n, alu_z, alu_v} = f;
        nc();
        flag_we = 3'b000; {alu_n, alu_z, alu_v} = 3'b000;
    endtask

    task automatic br(input logic r, input logic [2:0] c, input logic [15:0] pc2,
                      input logic [8:0] imm, input logic [15:0] rs);
        br_reg = r; br_cond = c; br_pc2 = pc2; br_imm = imm; br_rs = rs;
        br_req = 1'b1;
        nc();
        br_req = 1'b0;
        nc();
    endtask

    task automatic chk_res(input string nm, input logic t, input logic [15:0] tgt);
        chk({nm, "_valid"},  32'(rd_valid),  32'd1);
        chk({nm, "_taken"},  32'(rd_taken),  32'(t));
        chk({nm, "_target"}, 32'(rd_target), 32'(tgt));
        chk({nm, "_flush"},  32'(flush),     32'(t));
    endtask

    logic [7:0] tbl [8];

    initial begin
        // taken mask per cond, bit index = {N,Z,V}
        tbl = '{8'h33, 8'hCC, 8'h03, 8'hF0, 8'hCF, 8'hFC, 8'hAA, 8'hFF};
        rst_n = 1'b0;
        {alu_n, alu_z, alu_v} = 3'b000; flag_we = 3'b000; flag_pend = 1'b0;
        br_req = 1'b0; br_reg = 1'b0; br_cond = 3'b000;
        br_pc2 = 16'h0; br_imm = 9'h0; br_rs = 16'h0;
        nc(); nc();
        chk("rst_flags",  32'(flags),     32'd0);
        chk("rst_rdy",    32'(br_rdy),    32'd1);
        chk("rst_valid",  32'(rd_valid),  32'd0);
        chk("rst_target", 32'(rd_target), 32'd0);
        chk("rst_flush",  32'(flush),     32'd0);
        rst_n = 1'b1;

        // flag write, then masked-off write with toggling alu bits
        flag_we = 3'b111; {alu_n, alu_z, alu_v} = 3'b010;
        nc();
        chk("we111_flags", 32'(flags),   32'h2);
        chk("we111_model", 32'(m_flags), 32'h2);
        flag_we = 3'b000; {alu_n, alu_z, alu_v} = 3'b111;
        nc();
        chk("we000_hold", 32'(flags), 32'h2);
        {alu_n, alu_z, alu_v} = 3'b000;

        // B EQ backwards, taken
        br(1'b0, 3'b001, 16'h0010, 9'h1FE, 16'h0);
        chk_res("b_eq", 1'b1, 16'h000C);
        chk("b_eq_model_tgt", 32'(m_target), 32'h000C);
        nc();
        chk("pulse_end_valid", 32'(rd_valid),  32'd0);
        chk("pulse_end_flush", 32'(flush),     32'd0);
        chk("hold_target",     32'(rd_target), 32'h000C);

        // B NEQ with Z=1, not taken
        br(1'b0, 3'b000, 16'h0010, 9'h005, 16'h0);
        chk_res("b_neq", 1'b0, 16'h0010);

        // stall behind pending writer, resolve on forwarded Z=0
        br_reg = 1'b0; br_cond = 3'b000; br_pc2 = 16'h0100; br_imm = 9'h004;
        br_req = 1'b1; flag_pend = 1'b1;
        nc();
        br_req = 1'b0;
        chk("wait_rdy1", 32'(br_rdy), 32'd0);
        nc();
        chk("wait_rdy2", 32'(br_rdy), 32'd0);
        nc();
        flag_pend = 1'b0; flag_we = 3'b010; {alu_n, alu_z, alu_v} = 3'b000;
        nc();
        flag_we = 3'b000;
        chk("wait_novalid", 32'(rd_valid), 32'd0);
        nc();
        chk_res("wait_res", 1'b1, 16'h0108);

        // BR on overflow, both ways; B wrap-around
        setf(3'b001);
        br(1'b1, 3'b110, 16'h0200, 9'h000, 16'hFFFE);
        chk_res("br_v1", 1'b1, 16'hFFFE);
        setf(3'b000);
        br(1'b1, 3'b110, 16'h0200, 9'h000, 16'hFFFE);
        chk_res("br_v0", 1'b0, 16'h0200);
        br(1'b0, 3'b111, 16'hFFFE, 9'h001, 16'h0);
        chk_res("b_wrap", 1'b1, 16'h0000);

        // reset while stalled in WAIT
        setf(3'b111);
        chk("pre_rst_flags", 32'(flags), 32'h7);
        br_cond = 3'b111; br_req = 1'b1; flag_pend = 1'b1;
        nc();
        br_req = 1'b0;
        nc();
        #2 rst_n = 1'b0; flag_pend = 1'b0;
        nc();
        #2 rst_n = 1'b1;
        nc();
        chk("rstw_flags", 32'(flags),  32'd0);
        chk("rstw_rdy",   32'(br_rdy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("rstw_novalid", 32'(rd_valid), 32'd0);
            nc();
        end

        // full condition table sweep
        for (int f = 0; f < 8; f++) begin
            setf(3'(f));
            for (int c = 0; c < 8; c++) begin
                br(1'b0, 3'(c), 16'(16 * c + 2 * f), 9'(f), 16'h0);
                chk($sformatf("sweep_c%0d_f%0d_valid", c, f), 32'(rd_valid), 32'd1);
                chk($sformatf("sweep_c%0d_f%0d_taken", c, f), 32'(rd_taken), 32'(tbl[c][f]));
            end
        end

        nc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
